// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter: N-port PULP req/gnt/rvalid arbiter in front of one single-port RAM.
// Round-robin by default; define SP_RAM_ARB_FIXED_PRIO_EN for fixed priority with starvation override.
module sp_ram_arbiter #(
  parameter int N_PORTS    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 8
) (
  input  logic                           clk,
  input  logic                           rstn_i,
  input  logic [N_PORTS-1:0]             req_i,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]  addr_i,
  input  logic [N_PORTS-1:0]             we_i,
  input  logic [N_PORTS*DATA_WIDTH/8-1:0] be_i,
  input  logic [N_PORTS*DATA_WIDTH-1:0]  wdata_i,
  output logic [N_PORTS-1:0]             gnt_o,
  output logic [N_PORTS-1:0]             rvalid_o,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic                           ram_en_o,
  output logic [ADDR_WIDTH-1:0]          ram_addr_o,
  output logic                           ram_we_o,
  output logic [DATA_WIDTH/8-1:0]        ram_be_o,
  output logic [DATA_WIDTH-1:0]          ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]          ram_rdata_i
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int PTR_W = $clog2(N_PORTS);

  if (N_PORTS < 2 || N_PORTS > 4) begin : g_bad_n_ports
    $error("sp_ram_arbiter: N_PORTS must be 2..4");
  end
  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("sp_ram_arbiter: MAX_WAIT must be 1..255");
  end

  logic             found;
  logic [PTR_W-1:0] win;
  logic             resp_valid;
  logic [PTR_W-1:0] resp_owner;

`ifdef SP_RAM_ARB_FIXED_PRIO_EN
  logic [7:0]         wait_cnt [N_PORTS];
  logic [N_PORTS-1:0] starving;
  logic               hit;

  // Plain priority pick first, then a starving port (lowest index) overrides it.
  always_comb begin
    starving = '0;
    found    = 1'b0;
    win      = '0;
    hit      = 1'b0;
    for (int unsigned k = 1; k < N_PORTS; k++) begin
      starving[k] = req_i[k] && (wait_cnt[k] >= 8'(MAX_WAIT));
    end
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      if (!found && req_i[k]) begin
        found = 1'b1;
        win   = PTR_W'(k);
      end
    end
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      if (!hit && starving[k]) begin
        hit = 1'b1;
        win = PTR_W'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned k = 0; k < N_PORTS; k++) wait_cnt[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < N_PORTS; k++) begin
        if (k == 0) begin
          wait_cnt[k] <= '0;
        end else if (req_i[k] && !gnt_o[k]) begin
          wait_cnt[k] <= (wait_cnt[k] == 8'hFF) ? wait_cnt[k] : wait_cnt[k] + 8'd1;
        end else begin
          wait_cnt[k] <= '0;
        end
      end
    end
  end
`else
  logic [PTR_W-1:0] rr_ptr;
  int unsigned      idx;

  // Rotating search starting at rr_ptr; idx wraps without a modulo operator.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      if (!found && req_i[PTR_W'(idx)]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_ptr <= '0;
    end else if (found) begin
      rr_ptr <= (win == PTR_W'(N_PORTS - 1)) ? '0 : win + 1'b1;
    end
  end
`endif

  always_comb begin
    gnt_o = '0;
    if (found) gnt_o[win] = 1'b1;
  end

  // win is 0 when idle, so the RAM data lines fall back to port 0.
  assign ram_en_o    = found;
  assign ram_addr_o  = addr_i[win*ADDR_WIDTH +: ADDR_WIDTH];
  assign ram_we_o    = we_i[win];
  assign ram_be_o    = be_i[win*BE_W +: BE_W];
  assign ram_wdata_o = wdata_i[win*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      resp_valid <= 1'b0;
      resp_owner <= '0;
    end else begin
      resp_valid <= found;
      if (found) resp_owner <= win;
    end
  end

  always_comb begin
    rvalid_o = '0;
    if (resp_valid) rvalid_o[resp_owner] = 1'b1;
  end

  assign rdata_o = ram_rdata_i;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Self-checking bench for sp_ram_arbiter (3 ports): directed literal checks plus a
// randomized run compared every cycle against a behavioural arbitration/memory model.
module tb_sp_ram_arbiter;

  localparam int NP = 3;
  localparam int MW = 4;

  logic            clk;
  logic            rstn_i;
  logic [NP-1:0]   req_i;
  logic [NP*32-1:0] addr_i;
  logic [NP-1:0]   we_i;
  logic [NP*4-1:0] be_i;
  logic [NP*32-1:0] wdata_i;
  logic [NP-1:0]   gnt_o;
  logic [NP-1:0]   rvalid_o;
  logic [31:0]     rdata_o;
  logic            ram_en_o;
  logic [31:0]     ram_addr_o;
  logic            ram_we_o;
  logic [3:0]      ram_be_o;
  logic [31:0]     ram_wdata_o;
  logic [31:0]     ram_rdata_i;

  sp_ram_arbiter #(
    .N_PORTS(NP), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(MW)
  ) dut (
    .clk(clk), .rstn_i(rstn_i), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o),
    .ram_we_o(ram_we_o), .ram_be_o(ram_be_o), .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    merge = old;
    for (int b = 0; b < 4; b++) if (be[b]) merge[8*b +: 8] = d[8*b +: 8];
  endfunction

  // RAM behind the arbiter: read data one cycle after the enable.
  logic [31:0] ram [64];
  initial for (int i = 0; i < 64; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) begin
        ram[ram_addr_o[7:2]] <= merge(ram[ram_addr_o[7:2]], ram_wdata_o, ram_be_o);
        ram_rdata_i <= $urandom;
      end else begin
        ram_rdata_i <= ram[ram_addr_o[7:2]];
      end
    end
  end

  // Reference model state.
  logic [31:0] m_mem [64];
  initial for (int i = 0; i < 64; i++) m_mem[i] = '0;
  int          m_last = NP - 1;
  int          m_wait [NP];
  bit          exp_rv = 0;
  int          exp_owner = 0;
  bit          exp_isread = 0;
  logic [31:0] exp_rdata = '0;
  logic [NP-1:0] seen_gnt = '0;

  function automatic int pick();
    int best = -1;
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
    for (int k = 1; k < NP; k++) if (best < 0 && req_i[k] && m_wait[k] >= MW) best = k;
    for (int k = 0; k < NP; k++) if (best < 0 && req_i[k]) best = k;
`else
    int bestd = NP;
    for (int p = 0; p < NP; p++) begin
      int d = (p - m_last - 1 + 2*NP) % NP;
      if (req_i[p] && d < bestd) begin best = p; bestd = d; end
    end
`endif
    return best;
  endfunction

  always @(negedge clk) begin
    int w;
    if (!rstn_i) begin
      m_last = NP - 1;
      for (int k = 0; k < NP; k++) m_wait[k] = 0;
      exp_rv = 0;
      seen_gnt = gnt_o;
      check("reset_rvalid", 64'(rvalid_o), 64'(0));
      check("reset_gnt", 64'(gnt_o), 64'(0));
    end else begin
      check("rvalid", 64'(rvalid_o), exp_rv ? (64'(1) << exp_owner) : 64'(0));
      if (exp_rv && exp_isread) check("rdata", 64'(rdata_o), 64'(exp_rdata));
      w = pick();
      check("gnt", 64'(gnt_o), (w >= 0) ? (64'(1) << w) : 64'(0));
      check("ram_en", 64'(ram_en_o), 64'(w >= 0));
      if (w >= 0) begin
        check("ram_addr", 64'(ram_addr_o), 64'(addr_i[w*32 +: 32]));
        check("ram_we", 64'(ram_we_o), 64'(we_i[w]));
        check("ram_be", 64'(ram_be_o), 64'(be_i[w*4 +: 4]));
        if (we_i[w]) check("ram_wdata", 64'(ram_wdata_o), 64'(wdata_i[w*32 +: 32]));
        exp_isread = !we_i[w];
        if (we_i[w])
          m_mem[addr_i[w*32+2 +: 6]] = merge(m_mem[addr_i[w*32+2 +: 6]],
                                             wdata_i[w*32 +: 32], be_i[w*4 +: 4]);
        else
          exp_rdata = m_mem[addr_i[w*32+2 +: 6]];
        m_last = w;
      end
      exp_rv = (w >= 0);
      if (w >= 0) exp_owner = w;
      for (int k = 1; k < NP; k++)
        m_wait[k] = (req_i[k] && w != k) ? ((m_wait[k] < 255) ? m_wait[k] + 1 : 255) : 0;
      seen_gnt = gnt_o;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic r, input logic w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] d);
    req_i[p] = r;
    we_i[p] = w;
    addr_i[p*32 +: 32] = a;
    be_i[p*4 +: 4] = b;
    wdata_i[p*32 +: 32] = d;
  endtask

  task automatic do_reset();
    cyc();
    rstn_i = 1'b0;
    req_i = '0;
    cyc();
    rstn_i = 1'b1;
  endtask

  logic [NP-1:0] exp_b [6];
  logic [NP-1:0] exp_d [4];

  initial begin
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
    exp_b = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b001};
    exp_d = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
    exp_b = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010};
    exp_d = '{3'b100, 3'b001, 3'b100, 3'b001};
`endif
    rstn_i = 1'b0;
    req_i = '0; we_i = '0; addr_i = '0; be_i = '0; wdata_i = '0;
    repeat (3) @(posedge clk);
    #1 rstn_i = 1'b1;
    @(negedge clk);
    check("post_reset_rvalid", 64'(rvalid_o), 64'(0));

    // Write then read back through port 0.
    cyc(); set_port(0, 1, 1, 32'h40, 4'hF, 32'hDEADBEEF);
    @(negedge clk); check("wr_gnt", 64'(gnt_o), 64'(3'b001));
    cyc(); set_port(0, 1, 0, 32'h40, 4'hF, 32'h0);
    @(negedge clk); check("rd_gnt", 64'(gnt_o), 64'(3'b001));
    cyc(); req_i = '0;
    @(negedge clk);
    check("rd_rvalid", 64'(rvalid_o), 64'(3'b001));
    check("rd_rdata", 64'(rdata_o), 64'(32'hDEADBEEF));

    // Ports 0 and 1 requesting continuously.
    do_reset();
    cyc();
    set_port(0, 1, 0, 32'h40, 4'hF, 32'h0);
    set_port(1, 1, 0, 32'h44, 4'hF, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); check("pair_gnt", 64'(gnt_o), 64'(exp_b[i]));
      cyc();
    end
    req_i = '0;

    // Partial write on a zero word.
    cyc(); set_port(1, 1, 1, 32'h80, 4'h4, 32'h11223344);
    @(negedge clk);
    cyc(); set_port(1, 1, 0, 32'h80, 4'hF, 32'h0);
    @(negedge clk);
    cyc(); req_i = '0;
    @(negedge clk);
    check("partial_rvalid", 64'(rvalid_o), 64'(3'b010));
    check("partial_rdata", 64'(rdata_o), 64'(32'h00220000));

    // Pointer at 2 after a port-1 grant, then ports 2 and 0 compete.
    do_reset();
    cyc(); set_port(1, 1, 0, 32'h0, 4'hF, 32'h0);
    @(negedge clk);
    cyc();
    req_i = '0;
    set_port(0, 1, 0, 32'h4, 4'hF, 32'h0);
    set_port(2, 1, 0, 32'h8, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("wrap_gnt", 64'(gnt_o), 64'(exp_d[i]));
      cyc();
    end
    req_i = '0;

    // Reset in the cycle after a grant drops the response.
    cyc(); set_port(0, 1, 0, 32'h40, 4'hF, 32'h0);
    @(negedge clk); check("pre_rst_gnt", 64'(gnt_o), 64'(3'b001));
    cyc(); rstn_i = 1'b0; req_i = '0;
    @(negedge clk); check("dropped_rvalid", 64'(rvalid_o), 64'(0));
    cyc(); rstn_i = 1'b1;
    @(negedge clk); check("after_rst_rvalid", 64'(rvalid_o), 64'(0));
    cyc();
    set_port(0, 1, 0, 32'h40, 4'hF, 32'h0);
    set_port(1, 1, 0, 32'h44, 4'hF, 32'h0);
    @(negedge clk); check("after_rst_gnt", 64'(gnt_o), 64'(3'b001));
    cyc(); req_i = '0;

    // Randomized traffic; a pending request is held until granted.
    for (int c = 0; c < 400; c++) begin
      cyc();
      if (c == 200) begin rstn_i = 1'b0; req_i = '0; continue; end
      if (c == 201) rstn_i = 1'b1;
      for (int p = 0; p < NP; p++) begin
        if (req_i[p] && !seen_gnt[p]) continue;
        set_port(p, 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 63)) << 2, 4'($urandom_range(1, 15)), $urandom);
      end
    end
    cyc(); req_i = '0;
    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sp_ram_arbiter.md
# sp_ram_arbiter

Arbitrates between N_PORTS requesters that share one `sp_ram_wrap` instance. Each requester uses the PULP req/gnt/rvalid protocol. The arbiter grants at most one request per cycle and drives the RAM port combinationally in the grant cycle. It returns read data with `rvalid` to the owning port one cycle later. It sits between the core-side masters (instruction fetch, LSU, debug/DMA) and the RAM wrapper.

## Interface
Parameters:
- `N_PORTS`, 2, number of requesters; legal range 2..4.
- `ADDR_WIDTH`, 32, byte-address width; matches the RAM wrapper.
- `DATA_WIDTH`, 32, data width.
- `MAX_WAIT`, 8, starvation bound in cycles; used only when `SP_RAM_ARB_FIXED_PRIO_EN` is defined; legal range 1..255.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock; all state changes on the rising edge.
- `rstn_i`  in  1  asynchronous active-low reset.
- `req_i`  in  N_PORTS  per-port request.
- `addr_i`  in  N_PORTS×ADDR_WIDTH  per-port byte address.
- `we_i`  in  N_PORTS  per-port write enable.
- `be_i`  in  N_PORTS×DATA_WIDTH/8  per-port byte enables.
- `wdata_i`  in  N_PORTS×DATA_WIDTH  per-port write data.
- `gnt_o`  out  N_PORTS  one-hot-or-zero grant; combinational.
- `rvalid_o`  out  N_PORTS  one-hot-or-zero response valid; registered.
- `rdata_o`  out  DATA_WIDTH  shared response data; meaningful only with an `rvalid_o` bit set.
- `ram_en_o`  out  1  RAM enable.
- `ram_addr_o`  out  ADDR_WIDTH  RAM address.
- `ram_we_o`  out  1  RAM write enable.
- `ram_be_o`  out  DATA_WIDTH/8  RAM byte enables.
- `ram_wdata_o`  out  DATA_WIDTH  RAM write data.
- `ram_rdata_i`  in  DATA_WIDTH  RAM read data, valid one cycle after `ram_en_o`.

## Operation
- Winner selection each cycle:
  - Default: round-robin. Search starts at port `rr_ptr`, where `rr_ptr` is a register of width clog2(N_PORTS).
  - With `SP_RAM_ARB_FIXED_PRIO_EN` defined: fixed-priority selection as described under Configuration.
- Grant cycle: `gnt_o[w]`=1 and `ram_en_o`=1. The RAM outputs carry port w's addr/we/be/wdata unmodified.
- No request: `gnt_o`=0 and `ram_en_o`=0. The RAM data outputs are don't-care but are driven from port 0 to avoid X.
- Round-robin pointer: after a grant to port w, `rr_ptr` ← (w+1) mod N_PORTS. With N_PORTS=3 the pointer wraps 2→0. The pointer holds when nothing is granted.
- Response: registered `resp_valid` and `resp_owner` are captured on every grant, for both reads and writes.
  - In the next cycle, `rvalid_o[resp_owner]`=1.
  - `rdata_o` = `ram_rdata_i`. Write responses carry don't-care data.
- Back-to-back: a new grant can be issued in the same cycle as the previous response. Throughput is 1 access/cycle.
- Requesters hold req/addr/we/be/wdata until they see `gnt_o`. The arbiter does not check this.

## Timing
- Reset values:
  - `rr_ptr`=0, `resp_valid`=0, `resp_owner`=0, all starvation counters=0.
  - `rvalid_o`=0 during reset and in the first cycle after it.
  - `gnt_o` and `ram_en_o` are combinational and still follow `req_i` while `rstn_i`=0. Requesters must keep `req_i` low during reset.
- Latency: `gnt_o` in cycle T (0-cycle); `rvalid_o` and `rdata_o` in cycle T+1.
- Reset mid-operation: a response pending for T+1 is dropped, so no `rvalid_o` follows after reset. RAM contents are not affected by the arbiter.
- Simultaneous requests from all ports: exactly one `gnt_o` bit per cycle. Round-robin serves each port within N_PORTS cycles.
- `rdata_o` is not held; it is valid only in the `rvalid_o` cycle.

## Configuration
- Macro: `SP_RAM_ARB_FIXED_PRIO_EN`.
- Defined:
  - Port 0 has the highest priority, then 1, and so on.
  - Each port k>0 has an 8-bit wait counter. It increments while `req_i[k]`=1 and the port is not granted, and clears on grant or when `req_i[k]` drops.
  - Any port with wait counter ≥ `MAX_WAIT` overrides priority. The lowest-index starving port wins.
  - `rr_ptr` is unused; tie it to 0.
- Undefined: pure round-robin as described above, with no wait counters.

## Test plan
- Single port 0 read at addr 0x40 after a prior write of 0xDEADBEEF with be=0xF -> `gnt_o`=01 in T, then `rvalid_o`=01 and `rdata_o`=0xDEADBEEF in T+1.
- Ports 0 and 1 requesting continuously for 6 cycles (round-robin, N_PORTS=2) -> `gnt_o` sequence 01,10,01,10,01,10. `rvalid_o` follows one cycle later with matching owners.
- Partial write: port 1 write 0x11223344 with be=0x4 to a word holding 0 -> a later read returns 0x00220000.
- N_PORTS=3 with only ports 2 and 0 requesting, `rr_ptr`=2 -> grants 2,0,2,0; the pointer wraps correctly and port 1 is skipped.
- `SP_RAM_ARB_FIXED_PRIO_EN` defined, MAX_WAIT=4, ports 0 and 1 requesting continuously -> port 0 is granted 4 cycles, then port 1 once, and the pattern repeats.
- `rstn_i` asserted in the cycle after a grant -> no `rvalid_o` is seen. After release, `rr_ptr`=0 and a 2-port simultaneous request grants port 0 first.
